// File: rtl/temporal_pkg.sv
// Shared definitions for the race-logic encoder, decoder and temporal operators.
package temporal_pkg;

  localparam int unsigned GAMMA_DEFAULT  = 16;
  localparam int unsigned PULSE_DEFAULT  = 8;
  localparam int unsigned SLOT_W_DEFAULT = $clog2(GAMMA_DEFAULT);

  // Slot index within a gamma cycle for the default configuration.
  typedef logic [SLOT_W_DEFAULT-1:0] gamma_slot_t;

  // A spike time at or beyond the gamma cycle length never fires: "infinity".
  function automatic logic is_inf(input logic [31:0] value,
                                  input int unsigned gamma_cycle_width);
    return value >= gamma_cycle_width;
  endfunction

endpackage

// File: rtl/gamma_counter.sv
// Gamma-cycle slot counter: free-runs 0..GAMMA_CYCLE_WIDTH-1 while enabled,
// flags the upcoming slot-0 entry and drives the registered gamma reset strobe.
module gamma_counter
  import temporal_pkg::*;
#(
  parameter  int unsigned GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
  localparam int unsigned SLOT_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                  aclk,
  input  logic                  grst_n,
  input  logic                  en,
  output logic [SLOT_WIDTH-1:0] slot,
  output logic                  wrap_next,
  output logic                  gamma_rst
);

  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

  // High once the counter is live; the first enabled edge enters slot 0.
  logic running;

  // Next edge enters slot 0: either the cycle wraps or the counter starts up.
  assign wrap_next = en & (~running | (slot == LAST_SLOT));

  // Slot counter with run flag and registered slot-0 strobe.
  always_ff @(posedge aclk or negedge grst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    if (!grst_n) begin
      slot      <= '0;
      running   <= 1'b0;
      gamma_rst <= 1'b0;
    end else if (en) begin
      slot      <= wrap_next ? '0 : slot + 1'b1;
      running   <= 1'b1;
      gamma_rst <= wrap_next;
    end else begin
      slot      <= '0;
      running   <= 1'b0;
      gamma_rst <= 1'b0;
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-race-logic encoder: accepts a spike time over valid/ready,
// stages it, and emits one truncated pulse per gamma cycle at that offset.
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter  int unsigned GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
  parameter  int unsigned PULSE_WIDTH       = PULSE_DEFAULT,
  parameter  int unsigned VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  localparam int unsigned SLOT_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                   aclk,
  input  logic                   grst_n,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VALUE_WIDTH-1:0] in_value,
  output logic                   gamma_rst,
  output logic                   spike,
  output logic                   underrun
);

  localparam logic [VALUE_WIDTH-1:0] INF_VALUE = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH);

  logic [SLOT_WIDTH-1:0]  slot;
  logic [SLOT_WIDTH-1:0]  slot_next;
  logic                   wrap_next;
  logic                   stage_full;
  logic [VALUE_WIDTH-1:0] stage_value;
  logic [VALUE_WIDTH-1:0] active_value;
  logic [VALUE_WIDTH-1:0] active_next;
  logic [VALUE_WIDTH:0]   pulse_end;
  logic                   transfer;
  logic                   spike_next;

  gamma_counter #(
    .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH)
  ) u_gamma_counter (
    .aclk      (aclk),
    .grst_n    (grst_n),
    .en        (en),
    .slot      (slot),
    .wrap_next (wrap_next),
    .gamma_rst (gamma_rst)
  );

  // Ready depends only on flop state, so no in_valid -> in_ready path exists.
  assign in_ready = ~stage_full;
  assign transfer = in_valid & ~stage_full;

  // Spike time that will be in force after the next edge.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    active_next = active_value;
    if (wrap_next) begin
      active_next = stage_full ? stage_value : INF_VALUE;
    end
  end

  // Slot the counter is about to enter; only meaningful while en is high.
  assign slot_next = wrap_next ? '0 : slot + 1'b1;

  // Pulse end computed one bit wider so t+PULSE_WIDTH never wraps.
  assign pulse_end = (VALUE_WIDTH+1)'(active_next) + (VALUE_WIDTH+1)'(PULSE_WIDTH);

  // The slot counter never exceeds GAMMA_CYCLE_WIDTH-1, so truncation at the
  // gamma boundary falls out of the window compare.
  assign spike_next = en
                    & ~is_inf(32'(active_next), GAMMA_CYCLE_WIDTH)
                    & (VALUE_WIDTH'(slot_next) >= active_next)
                    & ((VALUE_WIDTH+1)'(slot_next) < pulse_end);

  // Staging and active registers: boundary load empties staging, a
  // simultaneous transfer refills it with the new word.
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      stage_full   <= 1'b0;
      // NOTE: data registers are reset too; the cost is small and a reset
      // then leaves nothing stale that could be mistaken for a real value.
      stage_value  <= '0;
      active_value <= INF_VALUE;
    end else begin
      active_value <= active_next;
      stage_full   <= wrap_next ? transfer : (stage_full | transfer);
      if (transfer) begin
        stage_value <= in_value;
      end
    end
  end

  // Registered spike and underrun outputs so race logic sees no glitches.
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      spike    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      spike    <= spike_next;
      underrun <= wrap_next & ~stage_full;
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder: a behavioural slot model plus a
// scoreboard queue of accepted values popped at each gamma boundary.
module tb_temporal_encoder;
  import temporal_pkg::*;

  localparam int G   = 16;
  localparam int P   = 8;
  localparam int VW  = $clog2(G) + 1;
  localparam int INF = G;

  logic          aclk = 1'b0;
  logic          grst_n;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_value;
  logic          gamma_rst;
  logic          spike;
  logic          underrun;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: accepted values waiting for their gamma cycle.
  int sb_q[$];
  // Model state for the current cycle.
  int m_slot;
  bit m_run;
  int m_t;
  bit m_under;
  bit m_accepted;
  // Rising-edge observations.
  int rise_q[$];
  bit prev_spike;

  always #5 aclk = ~aclk;

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH (G),
    .PULSE_WIDTH       (P),
    .VALUE_WIDTH       (VW)
  ) dut (
    .aclk      (aclk),
    .grst_n    (grst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .gamma_rst (gamma_rst),
    .spike     (spike),
    .underrun  (underrun)
  );

  // Expected {gamma_rst, spike, underrun, in_ready} for the current cycle.
  function automatic logic [3:0] exp_vec();
    logic s;
    s = m_run && (m_t < G) && (m_slot >= m_t) && (m_slot < m_t + P);
    return {m_run && (m_slot == 0), s, m_under, sb_q.size() == 0};
  endfunction

  function automatic bit rises_are(input int n, input int e0, input int e1, input int e2);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    if (rise_q.size() != n) return 1'b0;
    for (int k = 0; k < n; k++) if (rise_q[k] != e[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string rise_str();
    string s;
    s = "";
    foreach (rise_q[k]) s = {s, $sformatf("%0d ", rise_q[k])};
    return s;
  endfunction

  task automatic reset_model();
    sb_q.delete();
    m_slot = 0; m_run = 0; m_t = INF; m_under = 0; m_accepted = 0;
  endtask

  // Advance one clock, updating the model for what that edge does; returns #1 after the edge.
  task automatic tick();
    bit bnd;
    int v;
    m_accepted = in_valid && (sb_q.size() == 0);
    v   = int'(in_value);
    bnd = en && (!m_run || m_slot == G - 1);
    @(posedge aclk);
    m_under = 0;
    if (bnd) begin
      if (sb_q.size() > 0) m_t = sb_q.pop_front();
      else begin m_t = INF; m_under = 1; end
    end
    if (m_accepted) sb_q.push_back(v);
    if (en) begin m_slot = bnd ? 0 : m_slot + 1; m_run = 1; end
    else    begin m_slot = 0; m_run = 0; end
    #1;
    if (spike && !prev_spike) rise_q.push_back(m_slot);
    prev_spike = spike;
  endtask

  task automatic test_reset();
    grst_n = 1'b0; en = 1'b0; in_valid = 1'b1; in_value = VW'(3);
    reset_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got=%b exp=0001", i, {gamma_rst, spike, underrun, in_ready});
      end
    end
    in_valid = 1'b0;
    grst_n   = 1'b1;
    prev_spike = 1'b0;
    tick();
    checks++;
    if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", {gamma_rst, spike, underrun, in_ready}, exp_vec());
    end
  endtask

  task automatic test_basic();
    en = 1'b1;
    rise_q.delete();
    for (int i = 0; i < 3 * G; i++) begin
      in_valid = (i == 0); in_value = VW'(5);
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL basic i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!rises_are(1, 5, 0, 0)) begin
      failures++;
      $display("FAIL basic_rises got=%s exp=5", rise_str());
    end
  endtask

  task automatic test_truncation();
    rise_q.delete();
    for (int i = 0; i < 4 * G; i++) begin
      in_valid = (i == 3) || (i == 2 * G + 3);
      in_value = (i < 2 * G) ? VW'(12) : VW'(0);
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL truncation i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!rises_are(2, 12, 0, 0)) begin
      failures++;
      $display("FAIL truncation_rises got=%s exp=12 0", rise_str());
    end
  endtask

  task automatic test_infinity();
    rise_q.delete();
    for (int i = 0; i < 4 * G; i++) begin
      in_valid = (i == 3) || (i == G + 3);
      in_value = (i < G) ? VW'(16) : VW'(31);
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL infinity i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rise_q.size() != 0) begin
      failures++;
      $display("FAIL infinity_rises got=%s exp=none", rise_str());
    end
  endtask

  task automatic test_back_to_back();
    int vals[3];
    int idx;
    int per_cycle;
    int max_per_cycle;
    vals[0] = 3; vals[1] = 4; vals[2] = 5;
    idx = 0; per_cycle = 0; max_per_cycle = 0;
    rise_q.delete();
    for (int i = 0; i < 5 * G; i++) begin
      in_valid = (idx < 3);
      in_value = (idx < 3) ? VW'(vals[idx]) : VW'(0);
      tick();
      if (m_slot == 0) per_cycle = 0;
      if (m_accepted) begin idx++; per_cycle++; end
      if (per_cycle > max_per_cycle) max_per_cycle = per_cycle;
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL back_to_back i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 3 || max_per_cycle != 1) begin
      failures++;
      $display("FAIL back_to_back_accepts got=%0d max_per_cycle=%0d exp=3 max=1", idx, max_per_cycle);
    end
    checks++;
    if (!rises_are(3, 3, 4, 5)) begin
      failures++;
      $display("FAIL back_to_back_rises got=%s exp=3 4 5", rise_str());
    end
  endtask

  task automatic test_mid_reset();
    bit reached;
    reached = 0;
    for (int i = 0; i < 3 * G && !reached; i++) begin
      in_valid = (i == 2) || (i == G + 2);
      in_value = (i < G) ? VW'(5) : VW'(9);
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL mid_reset_run i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
      if (m_run && m_t == 5 && m_slot == 7) reached = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL mid_reset_timeout got=no_slot7 exp=slot7");
    end
    #1 grst_n = 1'b0;
    #1;
    checks++;
    if ({gamma_rst, spike, underrun, in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset_async got=%b exp=0001", {gamma_rst, spike, underrun, in_ready});
    end
    @(posedge aclk); #1;
    grst_n = 1'b1;
    reset_model();
    prev_spike = spike;
    for (int i = 0; i < G + 2; i++) begin
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL mid_reset_restart i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_enable();
    bit sent9;
    bit reached;
    sent9 = 0; reached = 0;
    for (int i = 0; i < 3 * G && !reached; i++) begin
      in_valid = 1'b0;
      if (i == 0) begin in_valid = 1'b1; in_value = VW'(5); end
      else if (m_run && m_t == 5 && m_slot == 2 && !sent9) begin
        in_valid = 1'b1; in_value = VW'(9); sent9 = 1;
      end
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL enable_run i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
      if (m_run && m_t == 5 && m_slot == 6) reached = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (!reached || !sent9) begin
      failures++;
      $display("FAIL enable_timeout got=reached%0d_sent%0d exp=reached1_sent1", reached, sent9);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL enable_off i=%0d got=%b exp=%b", i, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
    end
    en = 1'b1;
    rise_q.delete();
    for (int i = 0; i < 2 * G; i++) begin
      tick();
      checks++;
      if ({gamma_rst, spike, underrun, in_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL enable_resume i=%0d slot=%0d got=%b exp=%b", i, m_slot, {gamma_rst, spike, underrun, in_ready}, exp_vec());
      end
    end
    checks++;
    if (!rises_are(1, 9, 0, 0)) begin
      failures++;
      $display("FAIL enable_kept_value got=%s exp=9", rise_str());
    end
  endtask

  initial begin
    prev_spike = 1'b0;
    test_reset();
    test_basic();
    test_truncation();
    test_infinity();
    test_back_to_back();
    test_mid_reset();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
